// File: rtl/ps2_dev_pkg.sv
// ---------------------------------------------------------------------------
// ps2_dev_pkg
// Shared definitions for the device-side PS/2 transceiver:
//   state_e     - top-level sequencer states
//   FRAME_BITS  - device-to-host frame length (start, 8 data, parity, stop)
//   RX_BITS     - host-to-device bits clocked in after request-to-send
//                 (8 data, parity, stop; the start bit is the RTS itself)
//   DATA_BITS   - payload width
//   odd_parity  - parity bit that makes data plus parity contain an odd
//                 number of ones
//   max3        - elaboration-time helper for sizing counters
// ---------------------------------------------------------------------------
package ps2_dev_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TX_BIT = 2'd1,
        RX_BIT = 2'd2,
        RX_ACK = 2'd3
    } state_e;

    localparam int FRAME_BITS = 11;
    localparam int RX_BITS    = 10;
    localparam int DATA_BITS  = 8;

    function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_dev_clkgen.sv
// ---------------------------------------------------------------------------
// ps2_dev_clkgen
// Half-period timer that paces the PS/2 clock the device generates.
// Ports:
//   clk, rst    - system clock, asynchronous active-low reset
//   run_i       - 1 while a frame is being clocked; 0 holds the count at 0
//   load_i      - restart a fresh half-period with phase load_h_i
//   load_h_i    - phase to start in on load (1 = H, clock released)
//   phase_h_o   - current phase: 1 = H (released), 0 = L (driven low)
//   mid_h_o     - strobe at cycle HALF_PERIOD/2 of an H phase
//   eop_o       - strobe on the last cycle of either phase
// ---------------------------------------------------------------------------
module ps2_dev_clkgen #(
    parameter int HALF_PERIOD = 2000,
    parameter int CNT_W       = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic load_i,
    input  logic load_h_i,
    output logic phase_h_o,
    output logic mid_h_o,
    output logic eop_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(HALF_PERIOD / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // Phases alternate on their own once running, so the sequencer only has
    // to pick the starting phase when it leaves IDLE.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load_i) begin
            cnt_d   = '0;
            phase_d = load_h_i;
        end else if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign phase_h_o = phase_q;
    assign eop_o     = run_i & (cnt_q == LAST_CNT);
    assign mid_h_o   = run_i & phase_q & (cnt_q == MID_CNT);

endmodule

// File: rtl/ps2_device_txrx.sv
// ---------------------------------------------------------------------------
// ps2_device_txrx
// Device (keyboard/mouse) end of a PS/2 link. Generates the PS/2 clock,
// sends device-to-host frames, detects host request-to-send and receives
// host-to-device command frames, answering each with the ACK pulse.
// Ports:
//   clk, rst       - system clock, asynchronous active-low reset
//   ps2_clk_in     - raw clock pad level
//   ps2_data_in    - raw data pad level
//   ps2_clk_oe     - 1 pulls the clock line low
//   ps2_data_oe    - 1 pulls the data line low
//   tx_valid/tx_data/tx_ready - byte handshake for device-to-host sends
//   tx_done        - pulse: frame fully sent
//   tx_abort       - pulse: host inhibited mid-frame, byte kept for retry
//   rx_valid       - pulse: host frame received, rx_err qualifies it
//   rx_data        - last received byte, held until the next rx_valid
//   busy           - a frame is in progress in either direction
// ---------------------------------------------------------------------------
module ps2_device_txrx
    import ps2_dev_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int IDLE_CYCLES = 2500,
    parameter int RTS_CYCLES  = 2000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk_in,
    input  logic                 ps2_data_in,
    output logic                 ps2_clk_oe,
    output logic                 ps2_data_oe,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 tx_abort,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_err,
    output logic                 busy
);

    localparam int               MAX_CYC     = max3(HALF_PERIOD, IDLE_CYCLES, RTS_CYCLES);
    localparam int               CNT_W       = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] IDLE_TH     = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] RTS_TH      = CNT_W'(RTS_CYCLES);
    localparam logic [3:0]       LAST_TX_BIT = 4'(FRAME_BITS - 1);
    localparam logic [3:0]       LAST_RX_BIT = 4'(RX_BITS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Pad synchronizers; lines idle high so they reset to 1.
    logic clk_meta_q, clk_s_q, data_meta_q, data_s_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta_q  <= 1'b1;
            clk_s_q     <= 1'b1;
            data_meta_q <= 1'b1;
            data_s_q    <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_s_q     <= clk_meta_q;
            data_meta_q <= ps2_data_in;
            data_s_q    <= data_meta_q;
        end
    end

    state_e                 state_q, state_d;
    logic [3:0]             bit_q, bit_d;
    logic                   pending_q, pending_d;
    logic [CNT_W-1:0]       idle_q, idle_d;
    logic [CNT_W-1:0]       rts_q, rts_d;
    logic                   tx_done_q, tx_done_d;
    logic                   tx_abort_q, tx_abort_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_err_q, rx_err_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic [DATA_BITS-1:0]   tx_byte_q;
    logic [RX_BITS-1:0]     rx_sh_q;

    logic run, load, load_h;
    logic phase_h, mid_h, eop;
    logic accept;
    logic [FRAME_BITS-1:0] tx_frame;
    logic tx_bit;

    ps2_dev_clkgen #(
        .HALF_PERIOD (HALF_PERIOD),
        .CNT_W       (CNT_W)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .run_i     (run),
        .load_i    (load),
        .load_h_i  (load_h),
        .phase_h_o (phase_h),
        .mid_h_o   (mid_h),
        .eop_o     (eop)
    );

    // tx_done masks ready for its own cycle so a byte offered alongside the
    // completion is taken one cycle later, never in the same cycle.
    assign tx_ready = (state_q == IDLE) & ~pending_q & ~tx_done_q;
    assign accept   = tx_valid & tx_ready;

    assign tx_frame = {1'b1, odd_parity(tx_byte_q), tx_byte_q, 1'b0};
    assign tx_bit   = (bit_q <= LAST_TX_BIT) ? tx_frame[bit_q] : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            pending_q  <= 1'b0;
            idle_q     <= '0;
            rts_q      <= '0;
            tx_done_q  <= 1'b0;
            tx_abort_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            pending_q  <= pending_d;
            idle_q     <= idle_d;
            rts_q      <= rts_d;
            tx_done_q  <= tx_done_d;
            tx_abort_q <= tx_abort_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            rx_data_q  <= rx_data_d;
        end
    end

    // Payload registers carry no reset; pending_q says whether tx_byte_q is
    // meaningful and rx_valid says when rx_sh_q has been consumed.
    always_ff @(posedge clk) begin
        if (accept) begin
            tx_byte_q <= tx_data;
        end
        // Shift in LSB first; after ten samples [0] holds d0 and [9] stop.
        if (state_q == RX_BIT && mid_h) begin
            rx_sh_q <= {data_s_q, rx_sh_q[RX_BITS-1:1]};
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        pending_d  = pending_q;
        idle_d     = '0;
        rts_d      = '0;
        tx_done_d  = 1'b0;
        tx_abort_d = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        rx_data_d  = rx_data_q;
        run        = 1'b0;
        load       = 1'b0;
        load_h     = 1'b0;

        case (state_q)
            IDLE: begin
                bit_d = '0;
                // A low clock (host inhibit) clears both timers here.
                idle_d = (clk_s_q & data_s_q)  ? sat_inc(idle_q) : '0;
                rts_d  = (clk_s_q & ~data_s_q) ? sat_inc(rts_q)  : '0;
                if (accept) begin
                    pending_d = 1'b1;
                end
                if (rts_q >= RTS_TH) begin
                    state_d = RX_BIT;
                    load    = 1'b1;
                    load_h  = 1'b0;
                    idle_d  = '0;
                    rts_d   = '0;
                end else if (pending_q && idle_q >= IDLE_TH) begin
                    state_d = TX_BIT;
                    load    = 1'b1;
                    load_h  = 1'b1;
                    idle_d  = '0;
                    rts_d   = '0;
                end
            end

            TX_BIT: begin
                run = 1'b1;
                if (eop) begin
                    if (phase_h) begin
                        // Host pulled the clock down while we released it;
                        // the stop bit is past the point of no return.
                        if (!clk_s_q && bit_q != LAST_TX_BIT) begin
                            tx_abort_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else if (bit_q == LAST_TX_BIT) begin
                        tx_done_d = 1'b1;
                        pending_d = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            RX_BIT: begin
                run = 1'b1;
                if (eop && phase_h) begin
                    if (bit_q == LAST_RX_BIT) begin
                        bit_d   = '0;
                        state_d = RX_ACK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end

            RX_ACK: begin
                run = 1'b1;
                if (eop && phase_h) begin
                    state_d    = IDLE;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q[DATA_BITS-1:0];
                    rx_err_d   = ~(^rx_sh_q[DATA_BITS:0]) | ~rx_sh_q[RX_BITS-1];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line drive decodes straight from reset flops so an async reset
    // releases both pads immediately.
    assign ps2_clk_oe  = (state_q != IDLE) & ~phase_h;
    assign ps2_data_oe = (state_q == TX_BIT) ? ~tx_bit : (state_q == RX_ACK);

    assign busy     = (state_q != IDLE);
    assign tx_done  = tx_done_q;
    assign tx_abort = tx_abort_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_ps2_device_txrx.sv
module tb_ps2_device_txrx;

    localparam int HP = 20;
    localparam int IC = 50;
    localparam int RC = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       host_clk_low = 1'b0;
    logic       host_data_low = 1'b0;
    logic       pad_clk, pad_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_done, tx_abort, rx_valid, rx_err, busy;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain wired-AND of device and host.
    assign pad_clk  = ~(ps2_clk_oe | host_clk_low);
    assign pad_data = ~(ps2_data_oe | host_data_low);

    ps2_device_txrx #(
        .HALF_PERIOD (HP),
        .IDLE_CYCLES (IC),
        .RTS_CYCLES  (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (pad_clk),
        .ps2_data_in (pad_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_abort    (tx_abort),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_err      (rx_err),
        .busy        (busy)
    );

    // Bus-functional host monitor: records the data line on each clock fall
    // the device generates, plus pulse counters.
    logic       prev_oe = 1'b0;
    int         fall_cyc[$];
    logic       fall_bit[$];
    int         txdone_cnt = 0, txabort_cnt = 0, rxvalid_cnt = 0;
    int         last_rx_cyc = 0, last_done_cyc = 0;
    logic [7:0] last_rx_data = 8'h00;
    logic       last_rx_err = 1'b0;

    always @(negedge clk) begin
        if (ps2_clk_oe && !prev_oe) begin
            fall_cyc.push_back(cyc);
            fall_bit.push_back(pad_data);
        end
        prev_oe = ps2_clk_oe;
        if (tx_done) begin
            txdone_cnt++;
            last_done_cyc = cyc;
        end
        if (tx_abort) txabort_cnt++;
        if (rx_valid) begin
            rxvalid_cnt++;
            last_rx_cyc  = cyc;
            last_rx_data = rx_data;
            last_rx_err  = rx_err;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    // Reference frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_falls();
        fall_cyc.delete();
        fall_bit.delete();
    endtask

    // Last 11 recorded falls as a frame, and how many fall-to-fall gaps
    // differ from one full PS/2 clock period.
    task automatic got_frame(output logic [10:0] f, output int bad_period);
        int n;
        n = fall_bit.size();
        f = '0;
        bad_period = 0;
        if (n >= 11) begin
            for (int k = 0; k < 11; k++) begin
                f[k] = fall_bit[n-11+k];
                if (k > 0 && (fall_cyc[n-11+k] - fall_cyc[n-12+k]) != 2*HP) bad_period++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (!tx_ready && n < 3000) begin
            tick();
            n++;
        end
        if (tx_ready) begin
            tx_data  = b;
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic wait_tx_done(input int start, output logic to);
        int n;
        n = 0;
        while (txdone_cnt == start && n < 3000) begin
            tick();
            n++;
        end
        to = (txdone_cnt == start);
    endtask

    // Host-to-device transfer: inhibit, RTS, then one bit per device clock
    // fall, then observe the ACK on the 11th fall and wait for rx_valid.
    task automatic host_send(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                             output logic ack_ok, output logic to);
        logic [9:0] bits;
        int ones, n, base, rxs;
        ones = $countones(b);
        bits[7:0] = b;
        bits[8]   = (((ones % 2) == 0) ? 1'b1 : 1'b0) ^ bad_par;
        bits[9]   = ~bad_stop;
        ack_ok = 1'b0;
        to     = 1'b0;
        rxs    = rxvalid_cnt;
        host_clk_low = 1'b1;
        repeat (60) tick();
        host_data_low = 1'b1;
        repeat (5) tick();
        host_clk_low = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (!to) begin
                base = fall_bit.size();
                n = 0;
                while (fall_bit.size() == base && n < 2000) begin
                    tick();
                    n++;
                end
                if (fall_bit.size() == base) begin
                    to = 1'b1;
                end else if (i < 10) begin
                    host_data_low = ~bits[i];
                end else begin
                    ack_ok = ps2_data_oe && !pad_data;
                    host_data_low = 1'b0;
                end
            end
        end
        if (!to) begin
            n = 0;
            while (rxvalid_cnt == rxs && n < 500) begin
                tick();
                n++;
            end
            to = (rxvalid_cnt == rxs);
        end
        host_data_low = 1'b0;
        host_clk_low  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL reset_oe: got %b, required 00", {ps2_clk_oe, ps2_data_oe});
        end
        checks++;
        if ({tx_done, tx_abort, rx_valid, rx_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, required 00000", {tx_done, tx_abort, rx_valid, rx_err, busy});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data: got %h, required 00", rx_data);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_ready: got %b, required 1", tx_ready);
        end
    endtask

    task automatic tx_frame_check(input string name, input logic [7:0] b);
        logic ok, to;
        logic [10:0] f;
        int bad, d0;
        clear_falls();
        d0 = txdone_cnt;
        send_byte(b, ok);
        checks++;
        if (!ok || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept: ok=%b tx_ready=%b, required ok=1 tx_ready=0", name, ok, tx_ready);
        end
        wait_tx_done(d0, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_done_timeout: tx_done not seen, required pulse", name);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_after: got %b, required 1", name, tx_ready);
        end
        repeat (5) tick();
        got_frame(f, bad);
        checks++;
        if (fall_bit.size() != 11) begin
            errors++;
            $display("FAIL %s_pulses: got %0d clock pulses, required 11", name, fall_bit.size());
        end
        checks++;
        if (f !== model_frame(b)) begin
            errors++;
            $display("FAIL %s_bits: got %b, required %b (bit10..bit0)", name, f, model_frame(b));
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_period: %0d gaps not %0d cycles, required 0", name, bad, 2*HP);
        end
        checks++;
        if (txdone_cnt - d0 != 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, required 1", name, txdone_cnt - d0);
        end
    endtask

    task automatic test_tx_basic();
        tx_frame_check("tx_1c", 8'h1C);
    endtask

    task automatic test_tx_random();
        for (int i = 0; i < 3; i++) begin
            tx_frame_check("tx_rand", 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_tx_abort();
        logic ok, to;
        logic [10:0] f;
        int bad, n, a0, d0;
        clear_falls();
        a0 = txabort_cnt;
        d0 = txdone_cnt;
        send_byte(8'h1C, ok);
        n = 0;
        while (fall_bit.size() < 4 && n < 2000) begin tick(); n++; end
        n = 0;
        while (ps2_clk_oe && n < 200) begin tick(); n++; end
        repeat (12) tick();
        host_clk_low = 1'b1;
        repeat (10) tick();
        host_clk_low = 1'b0;
        repeat (3) tick();
        checks++;
        if (txabort_cnt - a0 != 1) begin
            errors++;
            $display("FAIL abort_pulse: got %0d pulses, required 1", txabort_cnt - a0);
        end
        checks++;
        if (tx_ready !== 1'b0 || ps2_data_oe !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: tx_ready=%b data_oe=%b, required 0 0", tx_ready, ps2_data_oe);
        end
        clear_falls();
        wait_tx_done(d0, to);
        repeat (3) tick();
        got_frame(f, bad);
        checks++;
        if (to || fall_bit.size() != 11 || f !== model_frame(8'h1C)) begin
            errors++;
            $display("FAIL abort_retry: timeout=%b pulses=%0d bits=%b, required 0 11 %b",
                     to, fall_bit.size(), f, model_frame(8'h1C));
        end
    endtask

    task automatic rx_check(input string name, input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic ack, to;
        int r0;
        r0 = rxvalid_cnt;
        host_send(b, bad_par, bad_stop, ack, to);
        checks++;
        if (to || !ack) begin
            errors++;
            $display("FAIL %s_ack: timeout=%b ack=%b, required 0 1", name, to, ack);
        end
        checks++;
        if (rxvalid_cnt - r0 != 1 || last_rx_data !== b || last_rx_err !== (bad_par | bad_stop)) begin
            errors++;
            $display("FAIL %s_data: pulses=%0d data=%h err=%b, required 1 %h %b",
                     name, rxvalid_cnt - r0, last_rx_data, last_rx_err, b, bad_par | bad_stop);
        end
        repeat (2) tick();
        checks++;
        if (rx_data !== b || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: rx_data=%h busy=%b, required %h 0", name, rx_data, busy, b);
        end
    endtask

    task automatic test_rx();
        rx_check("rx_ff", 8'hFF, 1'b0, 1'b0);
        tx_frame_check("tx_fa", 8'hFA);
    endtask

    task automatic test_rx_errors();
        rx_check("rx_ed_par", 8'hED, 1'b1, 1'b0);
        rx_check("rx_stop", 8'h55, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            rx_check("rx_rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_tx_during_rts();
        logic ack, to, ok, to2;
        logic [10:0] f;
        logic [7:0] rb;
        int bad, d0, ready_hi, n;
        rb = 8'($urandom_range(0, 255));
        d0 = txdone_cnt;
        ready_hi = 0;
        to2 = 1'b1;
        ok = 1'b0;
        fork
            host_send(rb, 1'b0, 1'b0, ack, to);
            begin
                repeat (72) tick();
                send_byte(8'hAA, ok);
                n = 0;
                while (txdone_cnt == d0 && n < 5000) begin
                    if (tx_ready) ready_hi++;
                    tick();
                    n++;
                end
                to2 = (txdone_cnt == d0);
            end
        join
        repeat (3) tick();
        got_frame(f, bad);
        checks++;
        if (to || !ack || last_rx_data !== rb) begin
            errors++;
            $display("FAIL rts_rx: timeout=%b ack=%b data=%h, required 0 1 %h", to, ack, last_rx_data, rb);
        end
        checks++;
        if (!ok || to2 || ready_hi != 0) begin
            errors++;
            $display("FAIL rts_tx_ready: accepted=%b timeout=%b ready_high_cycles=%0d, required 1 0 0",
                     ok, to2, ready_hi);
        end
        checks++;
        if (!(last_rx_cyc < last_done_cyc) || f !== model_frame(8'hAA)) begin
            errors++;
            $display("FAIL rts_order: rx_cyc=%0d done_cyc=%0d bits=%b, required rx first and %b",
                     last_rx_cyc, last_done_cyc, f, model_frame(8'hAA));
        end
    endtask

    task automatic test_reset_mid_tx();
        logic ok;
        logic [7:0] b;
        int n, d0;
        b = 8'($urandom_range(0, 255)) & 8'hDF;  // d5 = 0 so bit 6 drives data low
        clear_falls();
        d0 = txdone_cnt;
        send_byte(b, ok);
        n = 0;
        while (fall_bit.size() < 6 && n < 2000) begin tick(); n++; end
        n = 0;
        while (ps2_clk_oe && n < 200) begin tick(); n++; end
        repeat (5) tick();
        checks++;
        if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: data_oe=%b busy=%b, required 1 1", ps2_data_oe, busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            errors++;
            $display("FAIL rst_async_oe: got %b, required 00", {ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        tick();
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: tx_ready=%b busy=%b, required 1 0", tx_ready, busy);
        end
        clear_falls();
        repeat (300) tick();
        checks++;
        if (txdone_cnt != d0 || fall_bit.size() != 0) begin
            errors++;
            $display("FAIL rst_no_done: tx_done=%0d pulses=%0d, required 0 0", txdone_cnt - d0, fall_bit.size());
        end
    endtask

    initial begin
        test_reset();
        test_tx_basic();
        test_tx_random();
        test_tx_abort();
        test_rx();
        test_rx_errors();
        test_tx_during_rts();
        test_reset_mid_tx();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
